esfa_cell_sequencer: RTL and testbench

- Initiator side of the ESFA memory-cell command bus: accepts one high-level request at a time from the host over a valid/ready handshake.
- Expands each request into one or two broadcast cell commands (selector, willWrite, operand bytes) driven to all NCELLS memory cells in parallel.
- Captures the registered per-cell responses (bool, result value, context) and reduces them by lowest-index priority into a single response.
- Sits between the host/top-level controller and the memory-cell array.

---
 rtl/esfa_cell_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_esfa_cell_sequencer.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/esfa_cell_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : esfa_cell_sequencer
// Function : Expands host requests into broadcast ESFA cell commands and
//            reduces the registered per-cell responses (lowest index wins).
// Revision : 1.0
// ============================================================================
module esfa_cell_sequencer #(
    parameter int         NCELLS   = 8,
    parameter logic [7:0] IDLE_SEL = 8'd1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_op,
    input  logic [7:0]            req_handle,
    input  logic [7:0]            req_index,
    input  logic [7:0]            req_value,
    input  logic [7:0]            req_metadata,
    input  logic                  req_is_metadata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_hit,
    output logic [7:0]            resp_value,
    output logic [7:0]            resp_context,
    output logic                  busy,
    output logic [7:0]            cell_selector,
    output logic                  cell_will_write,
    output logic [7:0]            cell_handle,
    output logic [7:0]            cell_index,
    output logic [7:0]            cell_value,
    output logic [7:0]            cell_metadata,
    output logic                  cell_is_metadata,
    input  logic [NCELLS-1:0]     cell_bool_in,
    input  logic [8*NCELLS-1:0]   cell_value_in,
    input  logic [8*NCELLS-1:0]   cell_context_in
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ISSUE   = 2'd1;
    localparam logic [1:0] c_ST_CAPTURE = 2'd2;
    localparam logic [1:0] c_ST_RESP    = 2'd3;

    localparam logic [1:0] c_OP_UPDATE  = 2'd0;
    localparam logic [1:0] c_OP_LOOKUP  = 2'd1;
    localparam logic [1:0] c_OP_CONGRUE = 2'd2;
    localparam logic [1:0] c_OP_ALLOC   = 2'd3;

    logic [1:0] r_state;
    logic       r_step;
    logic [1:0] r_op;
    logic       r_hitSticky;
    logic       r_reqReady;
    logic       r_busy;
    logic       r_respValid;
    logic       r_respHit;
    logic [7:0] r_respValue;
    logic [7:0] r_respContext;
    logic [7:0] r_selector;
    logic       r_willWrite;
    logic [7:0] r_handle;
    logic [7:0] r_index;
    logic [7:0] r_value;
    logic [7:0] r_metadata;
    logic       r_isMetadata;

    logic [7:0] w_cellValue   [NCELLS];
    logic [7:0] w_cellContext [NCELLS];
    logic       w_anyHit;
    logic [7:0] w_firstIdx;
    logic [7:0] w_firstValue;
    logic [7:0] w_firstContext;
    logic       w_moreSteps;

    // Command for a given step of an operation: {willWrite, selector}.
    function automatic logic [8:0] stepCmd(input logic [1:0] op, input logic step);
        logic [8:0] cmd;
        case (op)
            c_OP_UPDATE:  cmd = {1'b1, 8'd0};
            c_OP_LOOKUP:  cmd = {1'b0, 8'd1};
            c_OP_CONGRUE: cmd = step ? {1'b1, 8'd4} : {1'b1, 8'd3};
            default:      cmd = {1'b0, 8'd5};
        endcase
        return cmd;
    endfunction

    generate
        for (genvar g = 0; g < NCELLS; g++) begin : g_unpack
            assign w_cellValue[g]   = cell_value_in[8*g +: 8];
            assign w_cellContext[g] = cell_context_in[8*g +: 8];
        end
    endgenerate

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        w_anyHit       = |cell_bool_in;
        w_firstIdx     = 8'd0;
        w_firstValue   = 8'd0;
        w_firstContext = 8'd0;
        for (int i = NCELLS - 1; i >= 0; i--) begin
            if (cell_bool_in[i]) begin
                w_firstIdx     = 8'(i);
                w_firstValue   = w_cellValue[i];
                w_firstContext = w_cellContext[i];
            end
        end
    end

    assign w_moreSteps = (r_op == c_OP_CONGRUE) && !r_step;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_ST_IDLE;
            r_step        <= 1'b0;
            r_op          <= c_OP_UPDATE;
            r_hitSticky   <= 1'b0;
            r_reqReady    <= 1'b1;
            r_busy        <= 1'b0;
            r_respValid   <= 1'b0;
            r_respHit     <= 1'b0;
            r_respValue   <= 8'd0;
            r_respContext <= 8'd0;
            r_selector    <= IDLE_SEL;
            r_willWrite   <= 1'b0;
            r_handle      <= 8'd0;
            r_index       <= 8'd0;
            r_value       <= 8'd0;
            r_metadata    <= 8'd0;
            r_isMetadata  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (req_valid) begin
                        r_state                   <= c_ST_ISSUE;
                        r_step                    <= 1'b0;
                        r_op                      <= req_op;
                        r_hitSticky               <= 1'b0;
                        r_reqReady                <= 1'b0;
                        r_busy                    <= 1'b1;
                        r_handle                  <= req_handle;
                        r_index                   <= req_index;
                        r_value                   <= req_value;
                        r_metadata                <= req_metadata;
                        r_isMetadata              <= req_is_metadata;
                        {r_willWrite, r_selector} <= stepCmd(req_op, 1'b0);
                    end
                end
                c_ST_ISSUE: begin
                    r_willWrite <= 1'b0;
                    r_state     <= c_ST_CAPTURE;
                end
                c_ST_CAPTURE: begin
                    if (w_moreSteps) begin
                        r_hitSticky               <= w_anyHit;
                        r_step                    <= 1'b1;
                        {r_willWrite, r_selector} <= stepCmd(r_op, 1'b1);
                        r_state                   <= c_ST_ISSUE;
                    end else begin
                        r_respValid <= 1'b1;
                        r_respHit   <= w_anyHit | r_hitSticky;
                        if (r_op == c_OP_ALLOC) begin
                            r_respValue   <= w_firstIdx;
                            r_respContext <= 8'd0;
                        end else begin
                            r_respValue   <= w_firstValue;
                            r_respContext <= w_firstContext;
                        end
                        r_state <= c_ST_RESP;
                    end
                end
                c_ST_RESP: begin
                    if (resp_ready) begin
                        r_respValid <= 1'b0;
                        r_selector  <= IDLE_SEL;
                        r_reqReady  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= c_ST_IDLE;
                    r_willWrite <= 1'b0;
                    r_respValid <= 1'b0;
                    r_selector  <= IDLE_SEL;
                    r_reqReady  <= 1'b1;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready        = r_reqReady;
    assign busy             = r_busy;
    assign resp_valid       = r_respValid;
    assign resp_hit         = r_respHit;
    assign resp_value       = r_respValue;
    assign resp_context     = r_respContext;
    assign cell_selector    = r_selector;
    assign cell_will_write  = r_willWrite;
    assign cell_handle      = r_handle;
    assign cell_index       = r_index;
    assign cell_value       = r_value;
    assign cell_metadata    = r_metadata;
    assign cell_is_metadata = r_isMetadata;

endmodule
`default_nettype wire

// File: tb/tb_esfa_cell_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_esfa_cell_sequencer
// Function : Self-checking bench for esfa_cell_sequencer (directed table,
//            hand-written corner sequences and randomized reference checks).
// Revision : 1.0
// ============================================================================
module tb_esfa_cell_sequencer;

    localparam int         NCELLS   = 8;
    localparam logic [7:0] IDLE_SEL = 8'd1;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [7:0]  req_handle;
    logic [7:0]  req_index;
    logic [7:0]  req_value;
    logic [7:0]  req_metadata;
    logic        req_is_metadata;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_hit;
    logic [7:0]  resp_value;
    logic [7:0]  resp_context;
    logic        busy;
    logic [7:0]  cell_selector;
    logic        cell_will_write;
    logic [7:0]  cell_handle;
    logic [7:0]  cell_index;
    logic [7:0]  cell_value;
    logic [7:0]  cell_metadata;
    logic        cell_is_metadata;
    logic [7:0]  cellBool;
    logic [63:0] cellVal;
    logic [63:0] cellCtx;

    int nChecks = 0;
    int nFail   = 0;

    esfa_cell_sequencer #(.NCELLS(NCELLS), .IDLE_SEL(IDLE_SEL)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_op           (req_op),
        .req_handle       (req_handle),
        .req_index        (req_index),
        .req_value        (req_value),
        .req_metadata     (req_metadata),
        .req_is_metadata  (req_is_metadata),
        .resp_valid       (resp_valid),
        .resp_ready       (resp_ready),
        .resp_hit         (resp_hit),
        .resp_value       (resp_value),
        .resp_context     (resp_context),
        .busy             (busy),
        .cell_selector    (cell_selector),
        .cell_will_write  (cell_will_write),
        .cell_handle      (cell_handle),
        .cell_index       (cell_index),
        .cell_value       (cell_value),
        .cell_metadata    (cell_metadata),
        .cell_is_metadata (cell_is_metadata),
        .cell_bool_in     (cellBool),
        .cell_value_in    (cellVal),
        .cell_context_in  (cellCtx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  handle, index, value, metadata;
        logic        isMeta;
        logic [7:0]  bool0, bool1;
        logic [63:0] val0, ctx0, val1, ctx1;
        int          respDelay;   // -1: resp_ready already high at accept
        logic        expHit;
        logic [7:0]  expValue, expContext;
    } vec_t;

    vec_t vecs[8];

    function automatic vec_t mkVec(
        input logic [1:0] op, input logic [7:0] h, input logic [7:0] ix,
        input logic [7:0] va, input logic [7:0] md, input logic im,
        input logic [7:0] b0, input logic [63:0] v0, input logic [63:0] c0,
        input logic [7:0] b1, input logic [63:0] v1, input logic [63:0] c1,
        input int dly, input logic eh, input logic [7:0] ev, input logic [7:0] ec);
        vec_t v;
        v.op = op; v.handle = h; v.index = ix; v.value = va; v.metadata = md; v.isMeta = im;
        v.bool0 = b0; v.val0 = v0; v.ctx0 = c0;
        v.bool1 = b1; v.val1 = v1; v.ctx1 = c1;
        v.respDelay = dly; v.expHit = eh; v.expValue = ev; v.expContext = ec;
        return v;
    endfunction

    // Reference: reduce the final step's responses, lowest index first.
    function automatic vec_t refModel(input vec_t vin);
        vec_t        v;
        logic [7:0]  fin;
        logic [63:0] fv, fc, sh;
        int          first;
        v     = vin;
        fin   = (v.op == 2'd2) ? v.bool1 : v.bool0;
        fv    = (v.op == 2'd2) ? v.val1  : v.val0;
        fc    = (v.op == 2'd2) ? v.ctx1  : v.ctx0;
        first = -1;
        for (int i = 0; i < NCELLS; i++)
            if (fin[i] && first < 0) first = i;
        v.expHit = (fin != 8'd0) || (v.op == 2'd2 && v.bool0 != 8'd0);
        if (first < 0) begin
            v.expValue = 8'd0; v.expContext = 8'd0;
        end else if (v.op == 2'd3) begin
            v.expValue = 8'(first); v.expContext = 8'd0;
        end else begin
            sh = fv >> (8 * first); v.expValue   = sh[7:0];
            sh = fc >> (8 * first); v.expContext = sh[7:0];
        end
        return v;
    endfunction

    function automatic logic [7:0] expSel(input logic [1:0] op, input int s);
        case (op)
            2'd0:    return 8'd0;
            2'd1:    return 8'd1;
            2'd2:    return (s == 0) ? 8'd3 : 8'd4;
            default: return 8'd5;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write enable must never be high two sampled cycles in a row.
    logic prevWW = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            nChecks++;
            if (cell_will_write && prevWW) begin
                nFail++;
                $display("FAIL will_write_consecutive: actual=1 required=0 (t=%0t)", $time);
            end
        end
        prevWW = cell_will_write;
    end

    task automatic runOp(input vec_t v);
        int         nSteps;
        logic [7:0] sel;
        nSteps          = (v.op == 2'd2) ? 2 : 1;
        req_op          = v.op;
        req_handle      = v.handle;
        req_index       = v.index;
        req_value       = v.value;
        req_metadata    = v.metadata;
        req_is_metadata = v.isMeta;
        req_valid       = 1'b1;
        cellBool = v.bool0; cellVal = v.val0; cellCtx = v.ctx0;
        resp_ready = (v.respDelay < 0);
        check("idle_req_ready", req_ready, 1);
        tick();
        req_valid  = 1'b0;
        req_handle = ~v.handle; req_index = ~v.index; req_value = ~v.value;
        req_metadata = ~v.metadata; req_is_metadata = ~v.isMeta;
        for (int s = 0; s < nSteps; s++) begin
            if (s == 1) begin
                cellBool = v.bool1; cellVal = v.val1; cellCtx = v.ctx1;
            end
            sel = expSel(v.op, s);
            check("issue_selector", cell_selector, sel);
            check("issue_will_write", cell_will_write, (v.op == 2'd0 || v.op == 2'd2));
            check("issue_busy", busy, 1);
            check("issue_req_ready", req_ready, 0);
            check("issue_resp_valid", resp_valid, 0);
            check("held_handle", cell_handle, v.handle);
            check("held_value", cell_value, v.value);
            check("held_misc", {cell_index, cell_metadata, 7'd0, cell_is_metadata},
                  {v.index, v.metadata, 7'd0, v.isMeta});
            tick();
            check("capture_selector", cell_selector, sel);
            check("capture_will_write", cell_will_write, 0);
            check("capture_resp_valid", resp_valid, 0);
            tick();
        end
        check("resp_valid", resp_valid, 1);
        check("resp_hit", resp_hit, v.expHit);
        check("resp_value", resp_value, v.expValue);
        check("resp_context", resp_context, v.expContext);
        for (int d = 0; d < v.respDelay; d++) begin
            cellBool = 8'hFF; cellVal = ~cellVal;
            tick();
            check("hold_resp_valid", resp_valid, 1);
            check("hold_resp_data", {resp_hit, resp_value, resp_context},
                  {v.expHit, v.expValue, v.expContext});
            check("hold_req_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        tick();
        check("done_resp_valid", resp_valid, 0);
        check("done_req_ready", req_ready, 1);
        check("done_busy", busy, 0);
        check("done_selector", cell_selector, IDLE_SEL);
        resp_ready = 1'b0;
    endtask

    initial begin
        vec_t rv;
        reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
        req_op = 2'd0; req_handle = 8'd0; req_index = 8'd0; req_value = 8'd0;
        req_metadata = 8'd0; req_is_metadata = 1'b0;
        cellBool = 8'd0; cellVal = 64'd0; cellCtx = 64'd0;

        vecs[0] = mkVec(2'd1, 8'h05, 8'h10, 8'h20, 8'h30, 1'b0,
                        8'b0010_0100, 64'h0000_5500_0022_0000, 64'h0000_AA00_00C2_0000,
                        8'h00, 64'd0, 64'd0, 0, 1'b1, 8'h22, 8'hC2);
        vecs[1] = mkVec(2'd0, 8'h11, 8'h12, 8'hA7, 8'h14, 1'b1,
                        8'h00, 64'h0102_0304_0506_0708, 64'h1112_1314_1516_1718,
                        8'h00, 64'd0, 64'd0, 1, 1'b0, 8'h00, 8'h00);
        vecs[2] = mkVec(2'd2, 8'h21, 8'h22, 8'h23, 8'h24, 1'b0,
                        8'b0000_0010, 64'h0102_0304_0506_0708, 64'h1112_1314_1516_1718,
                        8'h00, 64'h2122_2324_2526_2728, 64'h3132_3334_3536_3738,
                        0, 1'b1, 8'h00, 8'h00);
        vecs[3] = mkVec(2'd3, 8'h41, 8'h42, 8'h43, 8'h44, 1'b1,
                        8'b1011_0000, 64'hDEAD_BEEF_CAFE_F00D, 64'h0123_4567_89AB_CDEF,
                        8'h00, 64'd0, 64'd0, 2, 1'b1, 8'h04, 8'h00);
        vecs[4] = mkVec(2'd3, 8'h51, 8'h52, 8'h53, 8'h54, 1'b0,
                        8'h00, 64'hDEAD_BEEF_CAFE_F00D, 64'h0123_4567_89AB_CDEF,
                        8'h00, 64'd0, 64'd0, -1, 1'b0, 8'h00, 8'h00);
        vecs[5] = mkVec(2'd2, 8'h61, 8'h62, 8'h63, 8'h64, 1'b1,
                        8'h00, 64'h0102_0304_0506_0708, 64'h1112_1314_1516_1718,
                        8'b1000_0001, 64'h7E00_0000_0000_003C, 64'h9900_0000_0000_005A,
                        5, 1'b1, 8'h3C, 8'h5A);
        vecs[6] = mkVec(2'd0, 8'h71, 8'h72, 8'h73, 8'h74, 1'b0,
                        8'b1000_0000, 64'h9D00_0000_0000_0011, 64'h4E00_0000_0000_0022,
                        8'h00, 64'd0, 64'd0, 0, 1'b1, 8'h9D, 8'h4E);
        vecs[7] = mkVec(2'd1, 8'h81, 8'h82, 8'h83, 8'h84, 1'b1,
                        8'hFF, 64'h0102_0304_0506_0708, 64'h1112_1314_1516_1718,
                        8'h00, 64'd0, 64'd0, -1, 1'b1, 8'h08, 8'h18);

        tick(); tick();
        reset = 1'b0;
        tick();
        check("reset_req_ready", req_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_selector", cell_selector, IDLE_SEL);
        check("reset_will_write", cell_will_write, 0);
        check("reset_resp", {resp_valid, resp_hit, resp_value, resp_context}, 0);
        check("reset_operands", {cell_handle, cell_index, cell_value, cell_metadata}, 0);

        for (int k = 0; k < 8; k++) runOp(vecs[k]);

        // Reset during the second ISSUE of a CONGRUE.
        req_op = 2'd2; req_handle = 8'h99; req_valid = 1'b1;
        cellBool = 8'hFF;
        tick();
        req_valid = 1'b0;
        tick(); tick();
        check("rst_mid_pre_selector", cell_selector, 8'd4);
        check("rst_mid_pre_will_write", cell_will_write, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_will_write", cell_will_write, 0);
        check("rst_mid_resp_valid", resp_valid, 0);
        check("rst_mid_state", {req_ready, busy}, 2'b10);
        check("rst_mid_selector", cell_selector, IDLE_SEL);
        tick(); tick(); tick();
        check("rst_mid_after_resp_valid", resp_valid, 0);
        check("rst_mid_after_busy", busy, 0);

        for (int k = 0; k < 40; k++) begin
            rv.op       = 2'($urandom_range(0, 3));
            rv.handle   = 8'($urandom); rv.index = 8'($urandom);
            rv.value    = 8'($urandom); rv.metadata = 8'($urandom);
            rv.isMeta   = 1'($urandom);
            rv.bool0    = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            rv.bool1    = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            rv.val0     = {$urandom, $urandom}; rv.ctx0 = {$urandom, $urandom};
            rv.val1     = {$urandom, $urandom}; rv.ctx1 = {$urandom, $urandom};
            rv.respDelay = int'($urandom_range(0, 3)) - 1;
            runOp(refModel(rv));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
`default_nettype wire
